// File: rtl/rx_pixel_prefetch.sv
// rx_pixel_prefetch: show-ahead pixel FIFO that keeps itself full with burst reads from frame memory
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   frame_start         frame boundary pulse; flushes the FIFO and restarts fetching at address 0
//   rd_req, rd_addr     burst request and its start word address, held until rd_ack
//   rd_ack              memory accepts the pending request
//   rd_valid, rd_data   one returned {R,G,B} word
//   Mem_Read, Mem_Data  consumer pop and FIFO head (24'h0 when empty)
//   level               words currently held in the FIFO
//   underflow, overflow sticky error flags, cleared by rst (underflow also by frame_start)
module rx_pixel_prefetch #(
    parameter int DEPTH       = 1024,
    parameter int BURST       = 64,
    parameter int FRAME_WORDS = 307200,
    parameter int ADDR_W      = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    output logic                   rd_req,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic                   rd_ack,
    input  logic                   rd_valid,
    input  logic [23:0]            rd_data,
    input  logic                   Mem_Read,
    output logic [23:0]            Mem_Data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   underflow,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = AW + 2;

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t          state, state_nxt;
    logic [23:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   outstanding, out_nxt;
    logic [ADDR_W-1:0] issued;
    logic            accept, empty, full, pop, push, room;

    assign accept   = rd_req && rd_ack;
    assign empty    = level == '0;
    assign full     = level == LW'(DEPTH);
    assign pop      = Mem_Read && !empty;
    // Words returning for a flushed frame, or arriving with frame_start, are discarded.
    assign push     = rd_valid && state != FLUSH && !frame_start && (!full || pop);
    assign out_nxt  = outstanding + (accept ? LW'(BURST) : '0) - LW'(rd_valid);
    // Credit check: FIFO contents plus words still in flight must leave room for a whole burst.
    assign room     = SW'(level) + SW'(outstanding) + SW'(BURST) <= SW'(DEPTH);
    assign Mem_Data = empty ? '0 : mem[rd_ptr];
    assign rd_addr  = issued;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (frame_start)        state_nxt = out_nxt != '0 ? FLUSH : IDLE;
        else if (state == IDLE) state_nxt = room && issued < ADDR_W'(FRAME_WORDS) ? REQ : IDLE;
        else if (state == REQ)  state_nxt = rd_ack ? IDLE : REQ;
        else                    state_nxt = out_nxt == '0 ? IDLE : FLUSH;
    end

    always_comb begin
        rd_req = state == REQ;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            outstanding <= '0;
            issued      <= '0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            outstanding <= out_nxt;
            if (rd_valid && state != FLUSH && !frame_start && full && !pop) overflow <= 1'b1;
            if (frame_start) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                level     <= '0;
                issued    <= '0;
                underflow <= 1'b0;
            end else begin
                if (Mem_Read && empty) underflow <= 1'b1;
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(push) - LW'(pop);
                if (accept) issued <= issued + ADDR_W'(BURST);
            end
        end
    end
endmodule

// File: tb/tb_rx_pixel_prefetch.sv
// tb_rx_pixel_prefetch: randomized bench for rx_pixel_prefetch against a queue-based reference model
module tb_rx_pixel_prefetch;
    localparam int DEPTH       = 1024;
    localparam int BURST       = 64;
    localparam int FRAME_WORDS = 8192;
    localparam int ADDR_W      = 20;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_start = 1'b0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack = 1'b0;
    logic              rd_valid = 1'b0;
    logic [23:0]       rd_data = '0;
    logic              Mem_Read = 1'b0;
    logic [23:0]       Mem_Data;
    logic [LW-1:0]     level;
    logic              underflow;
    logic              overflow;

    rx_pixel_prefetch #(
        .DEPTH(DEPTH), .BURST(BURST), .FRAME_WORDS(FRAME_WORDS), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .Mem_Read(Mem_Read), .Mem_Data(Mem_Data),
        .level(level), .underflow(underflow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents, memory return queue, credit and frame bookkeeping.
    logic [23:0] mq[$];
    logic [23:0] pend[$];
    int  m_out, m_issued, fid, ack_pct, val_pct, bursts, checks, errors;
    int  last_acc_addr;
    bit  flushing, m_under, m_over, prev_req, prev_acc, prev_fs;

    function automatic logic [23:0] pix(input int f, input int a);
        return {f[3:0], a[19:0]};
    endfunction

    task automatic model_clear();
        mq.delete();
        pend.delete();
        m_out = 0; m_issued = 0; flushing = 0; m_under = 0; m_over = 0;
        prev_req = 0; prev_acc = 0; prev_fs = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; frame_start = 1'b0; Mem_Read = 1'b0;
        rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus: compare outputs against the model, drive inputs, advance the model.
    task automatic step(input bit fs, input bit rd, input bit inj);
        logic [23:0] exp_data;
        bit acc, pop, v;
        int base;
        @(negedge clk);
        exp_data = mq.size() > 0 ? mq[0] : 24'h0;
        checks += 5;
        if (Mem_Data !== exp_data) begin errors++; $display("FAIL mem_data: got %h expected %h", Mem_Data, exp_data); end
        if (level !== LW'(mq.size())) begin errors++; $display("FAIL level: got %0d expected %0d", level, mq.size()); end
        if (underflow !== m_under) begin errors++; $display("FAIL underflow: got %b expected %b", underflow, m_under); end
        if (overflow !== m_over) begin errors++; $display("FAIL overflow: got %b expected %b", overflow, m_over); end
        if (rd_addr !== ADDR_W'(m_issued)) begin errors++; $display("FAIL rd_addr: got %0d expected %0d", rd_addr, m_issued); end
        checks += 2;
        if (rd_req === 1'b1 && (flushing || m_issued >= FRAME_WORDS || prev_acc || prev_fs)) begin
            errors++; $display("FAIL req_illegal: got rd_req=1 expected 0 (flush=%b issued=%0d)", flushing, m_issued);
        end
        if (prev_req && !prev_acc && !prev_fs && rd_req !== 1'b1) begin
            errors++; $display("FAIL req_hold: got rd_req=%b expected 1", rd_req);
        end
        frame_start = fs;
        Mem_Read    = rd;
        rd_ack      = rd_req && ($urandom_range(99) < ack_pct);
        if (inj) begin
            rd_valid = 1'b1; rd_data = 24'($urandom);
        end else if (pend.size() > 0 && $urandom_range(99) < val_pct) begin
            rd_valid = 1'b1; rd_data = pend[0];
        end else begin
            rd_valid = 1'b0; rd_data = '0;
        end
        acc = rd_req === 1'b1 && rd_ack === 1'b1;
        v = rd_valid;
        if (acc) begin
            checks++;
            if (mq.size() + m_out + BURST > DEPTH) begin
                errors++; $display("FAIL credit: got level+outstanding=%0d expected <= %0d", mq.size() + m_out, DEPTH - BURST);
            end
            last_acc_addr = int'(rd_addr);
        end
        prev_req = rd_req === 1'b1;
        @(posedge clk);
        base = m_issued;
        if (v && !inj) void'(pend.pop_front());
        if (acc) for (int i = 0; i < BURST; i++) pend.push_back(pix(fid, base + i));
        m_out += (acc ? BURST : 0) - (v ? 1 : 0);
        if (fs) begin
            mq.delete();
            m_under = 0;
            m_issued = 0;
            flushing = m_out != 0;
            fid++;
        end else begin
            pop = rd && mq.size() > 0;
            if (rd && mq.size() == 0) m_under = 1;
            if (pop) void'(mq.pop_front());
            if (v && !flushing) begin
                if (mq.size() < DEPTH) mq.push_back(rd_data);
                else m_over = 1;
            end
            if (acc) begin m_issued += BURST; bursts++; end
            if (flushing && m_out == 0) flushing = 0;
        end
        prev_acc = acc;
        prev_fs  = fs;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 6;
        if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", rd_req); end
        if (rd_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", rd_addr); end
        if (level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        if (Mem_Data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", Mem_Data); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_underflow();
        ack_pct = 0; val_pct = 0;
        step(0, 1, 0);
        checks += 3;
        if (underflow !== 1'b1) begin errors++; $display("FAIL empty_read_underflow: got %b expected 1", underflow); end
        if (level !== '0) begin errors++; $display("FAIL empty_read_level: got %0d expected 0", level); end
        if (Mem_Data !== '0) begin errors++; $display("FAIL empty_read_data: got %h expected 0", Mem_Data); end
        for (int i = 0; i < 4; i++) step(0, 0, 0);
    endtask

    task automatic test_fill();
        apply_reset();
        ack_pct = 100; val_pct = 100; bursts = 0; last_acc_addr = -1;
        for (int i = 0; i < 1500; i++) step(0, 0, 0);
        checks += 4;
        if (bursts != 16) begin errors++; $display("FAIL fill_bursts: got %0d expected 16", bursts); end
        if (last_acc_addr != 960) begin errors++; $display("FAIL fill_last_addr: got %0d expected 960", last_acc_addr); end
        if (level !== LW'(DEPTH)) begin errors++; $display("FAIL fill_level: got %0d expected %0d", level, DEPTH); end
        if (rd_req !== 1'b0) begin errors++; $display("FAIL fill_no_17th: got %b expected 0", rd_req); end
    endtask

    task automatic test_drain();
        logic [23:0] got;
        int min_level = DEPTH, bad = -1;
        logic [23:0] bad_got = '0;
        for (int k = 0; k < 640; k++) begin
            got = Mem_Data;
            step(0, 1, 0);
            if (bad < 0 && got !== pix(fid, k)) begin bad = k; bad_got = got; end
            if (int'(level) < min_level) min_level = int'(level);
        end
        checks += 3;
        if (bad >= 0) begin errors++; $display("FAIL drain_order: word %0d got %h expected %h", bad, bad_got, pix(fid, bad)); end
        if (min_level < 384) begin errors++; $display("FAIL drain_min_level: got %0d expected >= 384", min_level); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_flush();
        int n;
        apply_reset();
        ack_pct = 100; val_pct = 0;
        n = 0;
        while (m_out < 2 * BURST && n < 100) begin step(0, 0, 0); n++; end
        ack_pct = 0;
        step(1, 0, 0);
        checks += 3;
        if (rd_req !== 1'b0) begin errors++; $display("FAIL flush_req: got %b expected 0", rd_req); end
        if (level !== '0) begin errors++; $display("FAIL flush_level: got %0d expected 0", level); end
        if (rd_addr !== '0) begin errors++; $display("FAIL flush_addr: got %0d expected 0", rd_addr); end
        ack_pct = 100; val_pct = 100; bursts = 0; last_acc_addr = -1;
        n = 0;
        while (flushing && n < 400) begin step(0, 0, 0); n++; end
        checks += 2;
        if (flushing) begin errors++; $display("FAIL flush_timeout: got %0d cycles expected < 400", n); end
        if (level !== '0) begin errors++; $display("FAIL flush_discard_level: got %0d expected 0", level); end
        n = 0;
        while (bursts == 0 && n < 50) begin step(0, 0, 0); n++; end
        checks++;
        if (last_acc_addr != 0) begin errors++; $display("FAIL flush_restart_addr: got %0d expected 0", last_acc_addr); end
    endtask

    task automatic test_full_frame();
        int n = 0, reqs = 0;
        ack_pct = 70; val_pct = 80;
        while (!(m_issued == FRAME_WORDS && m_out == 0) && n < 40000) begin
            step(0, $urandom_range(9) < 9, 0);
            n++;
        end
        checks += 2;
        if (n >= 40000) begin errors++; $display("FAIL frame_timeout: got issued=%0d expected %0d", m_issued, FRAME_WORDS); end
        if (last_acc_addr != FRAME_WORDS - BURST) begin errors++; $display("FAIL frame_last_addr: got %0d expected %0d", last_acc_addr, FRAME_WORDS - BURST); end
        for (int i = 0; i < 200; i++) begin
            step(0, $urandom_range(1) == 1, 0);
            if (rd_req === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0) begin errors++; $display("FAIL frame_no_wrap: got %0d requests expected 0", reqs); end
        step(1, 0, 0);
        bursts = 0; last_acc_addr = -1; n = 0;
        while (bursts == 0 && n < 300) begin step(0, 0, 0); n++; end
        checks++;
        if (last_acc_addr != 0) begin errors++; $display("FAIL next_frame_addr: got %0d expected 0", last_acc_addr); end
    endtask

    task automatic test_back_to_back_full();
        int n = 0;
        apply_reset();
        ack_pct = 100; val_pct = 100;
        while (level !== LW'(DEPTH) && n < 2000) begin step(0, 0, 0); n++; end
        step(0, 1, 1);
        checks += 2;
        if (level !== LW'(DEPTH)) begin errors++; $display("FAIL pushpop_level: got %0d expected %0d", level, DEPTH); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL pushpop_overflow: got %b expected 0", overflow); end
        step(0, 0, 1);
        checks += 2;
        if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b expected 1", overflow); end
        if (level !== LW'(DEPTH)) begin errors++; $display("FAIL drop_level: got %0d expected %0d", level, DEPTH); end
        step(0, 0, 0);
    endtask

    task automatic test_midburst_reset();
        apply_reset();
        ack_pct = 100; val_pct = 50;
        step(0, 1, 0);
        for (int i = 0; i < 20; i++) step(0, $urandom_range(3) == 0, 0);
        apply_reset();
        checks += 6;
        if (rd_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", rd_req); end
        if (rd_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", rd_addr); end
        if (level !== '0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level); end
        if (Mem_Data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", Mem_Data); end
        if (underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow: got %b expected 0", underflow); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        ack_pct = 100; val_pct = 100;
        for (int i = 0; i < 200; i++) step(0, $urandom_range(1) == 1, 0);
    endtask

    initial begin
        checks = 0; errors = 0; fid = 0; bursts = 0; last_acc_addr = -1;
        ack_pct = 0; val_pct = 0;
        model_clear();
        test_reset();
        test_underflow();
        test_fill();
        test_drain();
        test_flush();
        test_full_frame();
        test_back_to_back_full();
        test_midburst_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
